// File: rtl/cu_data_write_coalescer_pkg.sv
// Shared types for the PageRank rank-result write coalescer.
// Cacheline geometry, line packet layout and FSM encoding.
package cu_data_write_coalescer_pkg;

  localparam int DATA_SIZE_WRITE_BITS      = 64;
  localparam int CACHELINE_DATA_WRITE_NUM  = 16;
  localparam int CACHELINE_WRITE_BITS      =
    DATA_SIZE_WRITE_BITS * CACHELINE_DATA_WRITE_NUM;
  localparam int CACHELINE_WRITE_BYTES     = CACHELINE_WRITE_BITS / 8;
  localparam int DATA_WRITE_TIMEOUT_CYCLES = 64;

  localparam logic [7:0] EDGE_DATA_WRITE_CONTROL_ID = 8'd7;

  localparam logic [63:0] ADDRESS_DATA_WRITE_ALIGN_MASK =
    ~64'(CACHELINE_WRITE_BYTES - 1);

  typedef struct packed {
    logic [63:0]                       address;
    logic [0:CACHELINE_WRITE_BITS-1]   data;
    logic [0:CACHELINE_WRITE_BYTES-1]  byte_enable;
    logic [7:0]                        cu_id;
  } DataWriteLinePacket;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ISSUE
  } data_write_coalescer_state;

endpackage

// File: rtl/cu_data_write_coalescer.sv
// Packs per-vertex rank results sharing a cacheline into one
// line buffer and issues each full/flushed line as one write.
module cu_data_write_coalescer
  import cu_data_write_coalescer_pkg::*;
#(
  parameter int         DATA_BITS      = DATA_SIZE_WRITE_BITS,
  parameter int         LINE_ELEMS     = CACHELINE_DATA_WRITE_NUM,
  parameter int         TIMEOUT_CYCLES = DATA_WRITE_TIMEOUT_CYCLES,
  parameter logic [7:0] CU_ID          = EDGE_DATA_WRITE_CONTROL_ID
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enabled_in,
  input  logic [63:0]                      array_base_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  input  logic [31:0]                      data_in_index,
  input  logic [DATA_BITS-1:0]             data_in_value,
  input  logic                             flush_in,
  output logic                             cmd_out_valid,
  input  logic                             cmd_out_ready,
  output logic [63:0]                      cmd_out_address,
  output logic [0:LINE_ELEMS*DATA_BITS-1]  cmd_out_data,
  output logic [0:LINE_ELEMS*DATA_BITS/8-1] cmd_out_byte_enable,
  output logic [7:0]                       cmd_out_cu_id,
  output logic [31:0]                      lines_written_out,
  output logic                             done_out
);

  localparam int SLOT_BITS  = $clog2(LINE_ELEMS);
  localparam int TAG_BITS   = 32 - SLOT_BITS;
  localparam int LINE_BITS  = LINE_ELEMS * DATA_BITS;
  localparam int ELEM_BYTES = DATA_BITS / 8;
  localparam int LINE_SHIFT = $clog2(LINE_BITS / 8);
  localparam int CNT_BITS   = $clog2(TIMEOUT_CYCLES + 1);

  data_write_coalescer_state state_q, state_d;

  logic [LINE_ELEMS-1:0] mask_q;
  logic [DATA_BITS-1:0]  data_q [LINE_ELEMS];
  logic [TAG_BITS-1:0]   tag_q;
  logic [63:0]           line_addr_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [31:0]           lines_q;

  logic [TAG_BITS-1:0]   in_tag;
  logic [SLOT_BITS-1:0]  in_slot;
  logic [LINE_ELEMS-1:0] slot_bit;
  logic [LINE_ELEMS-1:0] mask_acc;
  logic                  tag_miss;
  logic                  accept;
  logic                  timeout;
  logic                  issue_done;

  assign in_tag  = data_in_index[31:SLOT_BITS];
  assign in_slot = data_in_index[SLOT_BITS-1:0];

  // A mismatching element stalls upstream until this line drains.
  assign tag_miss = (state_q == FILL) && data_in_valid &&
                    (in_tag != tag_q);

  assign data_in_ready = !reset && enabled_in &&
                         (state_q != ISSUE) && !tag_miss;

  assign accept     = data_in_valid && data_in_ready;
  assign slot_bit   = LINE_ELEMS'(1) << in_slot;
  assign mask_acc   = mask_q | (accept ? slot_bit : '0);
  assign timeout    = (cnt_q == CNT_BITS'(TIMEOUT_CYCLES));
  assign issue_done = (state_q == ISSUE) && cmd_out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = (flush_in || &mask_acc) ? ISSUE : FILL;
      end
      FILL: begin
        if (&mask_acc || tag_miss || flush_in || timeout)
          state_d = ISSUE;
      end
      ISSUE: begin
        if (cmd_out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      tag_q       <= '0;
      line_addr_q <= '0;
      cnt_q       <= '0;
      lines_q     <= '0;
      for (int k = 0; k < LINE_ELEMS; k++)
        data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q[in_slot] <= data_in_value;
        mask_q          <= mask_acc;
        if (state_q == IDLE) begin
          tag_q       <= in_tag;
          line_addr_q <= (array_base_in & ADDRESS_DATA_WRITE_ALIGN_MASK)
                       + (64'(in_tag) << LINE_SHIFT);
        end
      end
      if (issue_done) begin
        mask_q  <= '0;
        lines_q <= lines_q + 32'd1;
      end
      if (accept || state_d != FILL)
        cnt_q <= '0;
      else if (!timeout)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  logic [0:LINE_BITS-1]   line_data;
  logic [0:LINE_BITS/8-1] line_be;

  // Invalid slots read as zero; enables are the mask widened per byte.
  for (genvar k = 0; k < LINE_ELEMS; k++) begin : g_slot
    assign line_data[k*DATA_BITS +: DATA_BITS] =
      mask_q[k] ? data_q[k] : '0;
    assign line_be[k*ELEM_BYTES +: ELEM_BYTES] = {ELEM_BYTES{mask_q[k]}};
  end

  DataWriteLinePacket line_pkt;

  assign line_pkt = '{
    address:     line_addr_q,
    data:        line_data,
    byte_enable: line_be,
    cu_id:       CU_ID
  };

  assign cmd_out_valid       = (state_q == ISSUE);
  assign cmd_out_address     = cmd_out_valid ? line_pkt.address : '0;
  assign cmd_out_data        = cmd_out_valid ? line_pkt.data : '0;
  assign cmd_out_byte_enable = cmd_out_valid ? line_pkt.byte_enable : '0;
  assign cmd_out_cu_id       = line_pkt.cu_id;
  assign lines_written_out   = lines_q;
  assign done_out            = (state_q == IDLE) && (mask_q == '0);

endmodule

// File: tb/tb_cu_data_write_coalescer.sv
// Bench for cu_data_write_coalescer: directed steps plus a random
// phase, both checked against a line-level reference model.
module tb_cu_data_write_coalescer;
  import cu_data_write_coalescer_pkg::*;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enabled_in = 1'b0;
  logic [63:0]   array_base_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [31:0]   data_in_index = '0;
  logic [63:0]   data_in_value = '0;
  logic          flush_in = 1'b0;
  logic          cmd_out_valid;
  logic          cmd_out_ready = 1'b1;
  logic [63:0]   cmd_out_address;
  logic [0:1023] cmd_out_data;
  logic [0:127]  cmd_out_byte_enable;
  logic [7:0]    cmd_out_cu_id;
  logic [31:0]   lines_written_out;
  logic          done_out;

  always #5 clock = ~clock;

  cu_data_write_coalescer dut (
    .clock               (clock),
    .reset               (reset),
    .enabled_in          (enabled_in),
    .array_base_in       (array_base_in),
    .data_in_valid       (data_in_valid),
    .data_in_ready       (data_in_ready),
    .data_in_index       (data_in_index),
    .data_in_value       (data_in_value),
    .flush_in            (flush_in),
    .cmd_out_valid       (cmd_out_valid),
    .cmd_out_ready       (cmd_out_ready),
    .cmd_out_address     (cmd_out_address),
    .cmd_out_data        (cmd_out_data),
    .cmd_out_byte_enable (cmd_out_byte_enable),
    .cmd_out_cu_id       (cmd_out_cu_id),
    .lines_written_out   (lines_written_out),
    .done_out            (done_out)
  );

  typedef struct {
    logic [63:0]   addr;
    logic [0:1023] data;
    logic [0:127]  be;
  } line_t;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 0;

  // Reference model: one open line, emitted by the coalescing rules.
  line_t       exp_q[$];
  line_t       got_q[$];
  bit          m_open = 0;
  int unsigned m_tag = 0;
  logic [63:0] m_val [16];
  bit   [15:0] m_mask = '0;
  logic [63:0] base = '0;
  int          exp_lines = 0;

  always @(posedge clock)
    if (!reset && cmd_out_valid && cmd_out_ready)
      got_q.push_back(line_t'{cmd_out_address, cmd_out_data,
                              cmd_out_byte_enable});

  task automatic chk(string tag, logic [1023:0] obs, logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_emit();
    line_t l;
    l.addr = (base & ~64'h7F) + 64'(m_tag) * 64'd128;
    l.data = '0;
    l.be   = '0;
    for (int k = 0; k < 16; k++)
      if (m_mask[k]) begin
        l.data[k*64 +: 64] = m_val[k];
        l.be[k*8 +: 8]     = 8'hFF;
      end
    exp_q.push_back(l);
    exp_lines++;
    m_open = 0;
    m_mask = '0;
  endtask

  task automatic m_send(int unsigned idx, logic [63:0] v, bit fl);
    if (m_open && idx / 16 != m_tag) m_emit();
    if (!m_open) begin
      m_open = 1;
      m_tag  = idx / 16;
    end
    m_val[idx % 16]  = v;
    m_mask[idx % 16] = 1'b1;
    if (&m_mask || fl) m_emit();
  endtask

  task automatic m_close();
    if (m_open) m_emit();
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
    if (rnd_ready) cmd_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic send(int unsigned idx, logic [63:0] v, bit fl);
    int n = 0;
    data_in_valid = 1'b1;
    data_in_index = idx;
    data_in_value = v;
    flush_in      = fl;
    smp();
    while (!data_in_ready && n < 300) begin
      adv();
      smp();
      n++;
    end
    chk("send_bound", n >= 300, 0);
    adv();
    data_in_valid = 1'b0;
    flush_in      = 1'b0;
    m_send(idx, v, fl);
  endtask

  task automatic chk_line(string tag, line_t e);
    chk({tag, "_valid"}, cmd_out_valid, 1);
    chk({tag, "_addr"}, cmd_out_address, e.addr);
    chk({tag, "_data"}, cmd_out_data, e.data);
    chk({tag, "_be"}, cmd_out_byte_enable, e.be);
  endtask

  task automatic cmp_q(string tag);
    line_t g, e;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_addr"}, g.addr, e.addr);
      chk({tag, "_data"}, g.data, e.data);
      chk({tag, "_be"}, g.be, e.be);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_valid"}, cmd_out_valid, 0);
    chk({tag, "_addr"}, cmd_out_address, 0);
    chk({tag, "_data"}, cmd_out_data, 0);
    chk({tag, "_be"}, cmd_out_byte_enable, 0);
    chk({tag, "_lines"}, lines_written_out, 0);
    chk({tag, "_done"}, done_out, 1);
  endtask

  initial begin
    logic [0:127] be_exp;
    logic [63:0]  v;
    int           d, n, r, cur_tag, tg;

    base          = 64'h1000;
    array_base_in = base;
    enabled_in    = 1'b1;
    data_in_valid = 1'b1;
    repeat (3) begin
      smp();
      chk("rst_ready", data_in_ready, 0);
      adv();
    end
    reset         = 1'b0;
    data_in_valid = 1'b0;
    smp();
    chk_idle_outputs("rst");
    chk("rst_cu_id", cmd_out_cu_id, EDGE_DATA_WRITE_CONTROL_ID);
    chk("rst_ready_idle", data_in_ready, 1);

    // Full line of 16 elements.
    for (int i = 0; i < 16; i++) send(i, 64'(i), 0);
    smp();
    chk_line("full", exp_q[$]);
    chk("full_addr_lit", cmd_out_address, 64'h1000);
    chk("full_be_ones", &cmd_out_byte_enable, 1);
    chk("full_slot5", cmd_out_data[320 +: 64], 64'h5);
    chk("full_ready_issue", data_in_ready, 0);
    adv();
    smp();
    chk("full_lines", lines_written_out, 1);
    chk("full_valid_drop", cmd_out_valid, 0);

    // Partial line closed by a mismatching tag.
    for (int i = 16; i < 19; i++) send(i, 64'(100 + i), 0);
    data_in_valid = 1'b1;
    data_in_index = 40;
    data_in_value = 64'hCAFE;
    m_send(40, 64'hCAFE, 0);
    smp();
    chk("mm_stall_ready", data_in_ready, 0);
    chk("mm_no_valid_yet", cmd_out_valid, 0);
    adv();
    smp();
    chk_line("mm", exp_q[$]);
    be_exp = '0;
    for (int i = 0; i < 24; i++) be_exp[i] = 1'b1;
    chk("mm_addr_lit", cmd_out_address, 64'h1080);
    chk("mm_be_lit", cmd_out_byte_enable, be_exp);
    adv();
    smp();
    chk("mm_idle_ready", data_in_ready, 1);
    adv();
    data_in_valid = 1'b0;
    flush_in = 1'b1;
    m_close();
    adv();
    flush_in = 1'b0;
    smp();
    chk_line("flush", exp_q[$]);
    be_exp = '0;
    for (int i = 64; i < 72; i++) be_exp[i] = 1'b1;
    chk("flush_addr_lit", cmd_out_address, 64'h1100);
    chk("flush_be_lit", cmd_out_byte_enable, be_exp);
    adv();
    smp();
    chk("flush_lines", lines_written_out, exp_lines);

    // Timeout on a lone element.
    send(3, 64'h33, 0);
    d = 0;
    smp();
    while (!cmd_out_valid && d < 200) begin
      adv();
      smp();
      d++;
    end
    chk("tmo_latency", d, 65);
    m_close();
    be_exp = '0;
    for (int i = 24; i < 32; i++) be_exp[i] = 1'b1;
    chk("tmo_be_lit", cmd_out_byte_enable, be_exp);
    chk_line("tmo", exp_q[$]);
    adv();
    smp();
    chk("tmo_lines", lines_written_out, exp_lines);

    // Backpressure: outputs hold for ten stalled cycles.
    cmd_out_ready = 1'b0;
    for (int i = 32; i < 48; i++) send(i, {$urandom, $urandom}, 0);
    smp();
    chk_line("bp_first", exp_q[$]);
    data_in_valid = 1'b1;
    data_in_index = 5;
    for (int i = 0; i < 10; i++) begin
      adv();
      smp();
      chk_line("bp_hold", exp_q[$]);
      chk("bp_in_ready", data_in_ready, 0);
    end
    data_in_valid = 1'b0;
    cmd_out_ready = 1'b1;
    adv();
    smp();
    chk("bp_done_valid", cmd_out_valid, 0);
    chk("bp_lines", lines_written_out, exp_lines);

    // Duplicate slot with flush on the second accept.
    send(7, 64'hA, 0);
    send(7, 64'hB, 1);
    smp();
    chk_line("dup", exp_q[$]);
    chk("dup_slot7", cmd_out_data[448 +: 64], 64'hB);
    adv();
    n = 0;
    repeat (5) begin
      smp();
      if (cmd_out_valid) n++;
      adv();
    end
    chk("dup_single_issue", n, 0);
    chk("dup_lines", lines_written_out, exp_lines);
    chk("dup_done", done_out, 1);

    // Enable low blocks accepts.
    enabled_in    = 1'b0;
    data_in_valid = 1'b1;
    data_in_index = 9;
    smp();
    chk("en_ready", data_in_ready, 0);
    adv();
    smp();
    chk("en_done", done_out, 1);
    data_in_valid = 1'b0;
    enabled_in    = 1'b1;
    cmp_q("dir");

    // Reset while a line is waiting in ISSUE.
    cmd_out_ready = 1'b0;
    send(20, 64'h20, 0);
    send(21, 64'h21, 1);
    smp();
    chk("rsti_valid", cmd_out_valid, 1);
    void'(exp_q.pop_back());
    m_open    = 0;
    m_mask    = '0;
    exp_lines = 0;
    reset = 1'b1;
    adv();
    reset = 1'b0;
    smp();
    chk_idle_outputs("rsti");
    cmp_q("rsti_q");

    // Random phase.
    base          = {$urandom, $urandom};
    array_base_in = base;
    rnd_ready     = 1;
    cur_tag       = 0;
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 99);
      if (r < 85) begin
        tg = (r < 60) ? cur_tag : $urandom_range(0, 3);
        cur_tag = tg;
        v = {$urandom, $urandom};
        send(tg * 16 + $urandom_range(0, 15), v, $urandom_range(0, 9) == 0);
      end else if (r < 95) begin
        flush_in = 1'b1;
        m_close();
        adv();
        flush_in = 1'b0;
      end else begin
        repeat (90) adv();
        m_close();
      end
      repeat ($urandom_range(0, 4)) adv();
    end
    flush_in = 1'b1;
    m_close();
    adv();
    flush_in = 1'b0;
    n = 0;
    while (!(done_out && got_q.size() == exp_q.size()) && n < 500) begin
      adv();
      n++;
    end
    smp();
    chk("rnd_drain_bound", n >= 500, 0);
    chk("rnd_lines", lines_written_out, exp_lines);
    chk("rnd_done", done_out, 1);
    cmp_q("rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
